seq_divider: RTL and testbench

- Iterative restoring divider; the inverse operation of the team's combinational Wallace multiplier.
- Takes a WIDTH-bit dividend and divisor and produces the quotient and remainder.
- Uses one quotient bit per clock and a start/done handshake.
- Sits beside the multiplier in the ALU datapath experiments. The sequencer issues start and waits for done.

---
 rtl/seq_divider_pkg.sv | 27 ++
 rtl/seq_divider_if.sv | 35 +++
 rtl/seq_divider_div_step.sv | 35 +++
 rtl/seq_divider.sv | 166 ++++++++++++++++
 tb/tb_seq_divider.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
// Shared types and constants for the iterative restoring divider.
//   div_state_t   : controller states (FIX is only reachable in the signed build)
//   SEQ_DIV_WIDTH : default operand width
//   SEQ_DIV_CNT_W : iteration counter width for the default operand width
//   cnt_width()   : counter width for an arbitrary operand width
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN (see seq_divider.sv)
// -----------------------------------------------------------------------------
package seq_divider_pkg;

    localparam int SEQ_DIV_WIDTH = 8;
    localparam int SEQ_DIV_CNT_W = $clog2(SEQ_DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // The counter must hold WIDTH-1; keep at least one bit for tiny widths.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Start/done handshake and operand/result bus between a sequencer and the
// divider.
//   start, dividend, divisor          : sequencer -> divider
//   ready, done, quotient, remainder,
//   div_by_zero                       : divider -> sequencer
// Modports: master (sequencer side), slave (divider side).
// -----------------------------------------------------------------------------
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = SEQ_DIV_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One purely combinational restoring-division iteration.
//   p      : current partial remainder (WIDTH+1 bits)
//   q_in   : next dividend bit shifted in (MSB of the Q shift register)
//   d      : divisor
//   p_next : partial remainder after the trial subtraction / restore
//   q_bit  : quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = SEQ_DIV_WIDTH
) (
    input  logic [WIDTH:0]   p,
    input  logic             q_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   p_next,
    output logic             q_bit
);

    // The partial remainder is always < d, so its top bit is zero; carrying
    // one extra bit through the subtraction keeps the sign of the trial result
    // unambiguous without relying on that invariant.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    assign shifted = {p, q_in};
    assign trial   = shifted - {2'b00, d};

    // Non-negative trial: keep the difference and emit a 1; otherwise restore.
    assign q_bit  = ~trial[WIDTH+1];
    assign p_next = trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative restoring divider, one quotient bit per clock, start/done handshake.
//   clk     : system clock, rising edge
//   arst_n  : asynchronous active-low reset
//   bus     : seq_divider_if.slave
//               start/dividend/divisor in; ready/done/quotient/remainder/
//               div_by_zero out (all outputs registered)
// Latency: done in cycle WIDTH+1 after the start edge, cycle 1 for a zero
// divisor.
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN
//   Two's-complement operands; magnitudes are divided and a FIX state applies
//   the signs (quotient truncates toward zero, remainder follows the dividend),
//   adding one cycle of latency.
// -----------------------------------------------------------------------------
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = SEQ_DIV_WIDTH
) (
    input  logic          clk,
    input  logic          arst_n,
    seq_divider_if.slave  bus
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       state_reg;
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             ready_reg;
    logic             done_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             div_by_zero_reg;

    logic [WIDTH:0]   step_p;
    logic             step_q;
    logic [WIDTH-1:0] q_shifted;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             neg_q_reg;
    logic             neg_r_reg;

    // The core only divides magnitudes. The most-negative value maps onto
    // itself, which read as unsigned is exactly its magnitude.
    assign dividend_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign divisor_mag  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
`else
    assign dividend_mag = bus.dividend;
    assign divisor_mag  = bus.divisor;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .p      (p_reg),
        .q_in   (q_reg[WIDTH-1]),
        .d      (d_reg),
        .p_next (step_p),
        .q_bit  (step_q)
    );

    assign q_shifted = {q_reg[WIDTH-2:0], step_q};

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg       <= IDLE;
            p_reg           <= '0;
            q_reg           <= '0;
            d_reg           <= '0;
            cnt_reg         <= '0;
            ready_reg       <= 1'b1;
            done_reg        <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            div_by_zero_reg <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q_reg       <= 1'b0;
            neg_r_reg       <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        q_reg     <= dividend_mag;
                        d_reg     <= divisor_mag;
                        p_reg     <= '0;
                        cnt_reg   <= CNT_LAST;
                        ready_reg <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_q_reg <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        neg_r_reg <= bus.dividend[WIDTH-1];
`endif
                        if (bus.divisor == '0) begin
                            // Skip the iterations; the raw dividend is
                            // reported as the remainder.
                            quotient_reg    <= '1;
                            remainder_reg   <= bus.dividend;
                            div_by_zero_reg <= 1'b1;
                            done_reg        <= 1'b1;
                            state_reg       <= DONE;
                        end else begin
                            state_reg <= CALC;
                        end
                    end
                end

                CALC: begin
                    p_reg <= step_p;
                    q_reg <= q_shifted;
                    if (cnt_reg == '0) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                        state_reg <= FIX;
`else
                        // Results are loaded together with done so they are
                        // valid in the same cycle as the pulse.
                        quotient_reg    <= q_shifted;
                        remainder_reg   <= step_p[WIDTH-1:0];
                        div_by_zero_reg <= 1'b0;
                        done_reg        <= 1'b1;
                        state_reg       <= DONE;
`endif
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end

`ifdef SEQ_DIVIDER_SIGNED_EN
                FIX: begin
                    quotient_reg    <= neg_q_reg ? -q_reg : q_reg;
                    remainder_reg   <= neg_r_reg ? -p_reg[WIDTH-1:0] : p_reg[WIDTH-1:0];
                    div_by_zero_reg <= 1'b0;
                    done_reg        <= 1'b1;
                    state_reg       <= DONE;
                end
`endif

                DONE: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end

                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready       = ready_reg;
    assign bus.done        = done_reg;
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed self-checking bench for seq_divider (WIDTH=8). Expected values are
// hand-computed; the signed set is used when SEQ_DIVIDER_SIGNED_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W = 8;
`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam int LAT = 10;
    // 200 is -56 as a signed byte: -56 / 7 = -8 remainder 0
    localparam logic [7:0] Q200 = 8'hF8;
    localparam logic [7:0] R200 = 8'h00;
`else
    localparam int LAT = 9;
    localparam logic [7:0] Q200 = 8'd28;
    localparam logic [7:0] R200 = 8'd4;
`endif

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one start, wait (bounded) for done, check latency and results,
    // then check that ready is back and done has dropped one cycle later.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edbz, input int elat);
        int cyc;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) break;
        end
        $display("op %s: %0h / %0h -> q=%0h r=%0h dbz=%0b after %0d cycles",
                 tag, a, b, bus.quotient, bus.remainder, bus.div_by_zero, cyc);
        check({tag, " latency"}, cyc, elat);
        check({tag, " quotient"}, bus.quotient, eq);
        check({tag, " remainder"}, bus.remainder, er);
        check({tag, " div_by_zero"}, bus.div_by_zero, edbz);
        @(negedge clk);
        check({tag, " ready after"}, bus.ready, 1'b1);
        check({tag, " done dropped"}, bus.done, 1'b0);
    endtask

    initial begin
        int cyc;
        int ndone;
        int first_cyc;
        int second_cyc;
        logic [7:0] q1, r1, q2, r2;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        arst_n       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset ready", bus.ready, 1'b1);
        check("reset done", bus.done, 1'b0);
        check("reset quotient", bus.quotient, 8'h00);
        check("reset remainder", bus.remainder, 8'h00);
        check("reset div_by_zero", bus.div_by_zero, 1'b0);
        $display("reset released");
        arst_n = 1'b1;

        // Normal and edge-value divisions
        run_op("200/7", 8'd200, 8'd7, Q200, R200, 1'b0, LAT);
        run_op("255/1", 8'd255, 8'd1, 8'hFF, 8'h00, 1'b0, LAT);
        run_op("3/10", 8'd3, 8'd10, 8'h00, 8'h03, 1'b0, LAT);
        run_op("255/255", 8'd255, 8'd255, 8'h01, 8'h00, 1'b0, LAT);

        // Divide by zero, then a normal op clears the flag
        run_op("5/0", 8'd5, 8'd0, 8'hFF, 8'h05, 1'b1, 1);
        run_op("9/3", 8'd9, 8'd3, 8'h03, 8'h00, 1'b0, LAT);

        // Handshake: start held high, operands changed mid-CALC
        first_cyc  = -1;
        second_cyc = -1;
        ndone      = 0;
        q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd7;
        @(posedge clk);
        #1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd9;
        cyc = 0;
        while (cyc < 3 * LAT && second_cyc < 0) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) begin
                ndone++;
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    q1 = bus.quotient;
                    r1 = bus.remainder;
                end else begin
                    second_cyc = cyc;
                    q2 = bus.quotient;
                    r2 = bus.remainder;
                end
            end
        end
        bus.start = 1'b0;
        $display("op held-start: first done cycle %0d q=%0h r=%0h, second done cycle %0d q=%0h r=%0h",
                 first_cyc, q1, r1, second_cyc, q2, r2);
        check("held first latency", first_cyc, LAT);
        check("held first quotient", q1, Q200);
        check("held first remainder", r1, R200);
        check("held second latency", second_cyc, 2 * LAT + 1);
        check("held second quotient", q2, 8'd11);
        check("held second remainder", r2, 8'd1);
        check("held done count", ndone, 2);
        @(negedge clk);

        // Reset in the middle of CALC
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        arst_n = 1'b0;
        #1;
        $display("op mid-reset: q=%0h r=%0h ready=%0b", bus.quotient, bus.remainder, bus.ready);
        check("midreset ready", bus.ready, 1'b1);
        check("midreset done", bus.done, 1'b0);
        check("midreset quotient", bus.quotient, 8'h00);
        check("midreset remainder", bus.remainder, 8'h00);
        check("midreset div_by_zero", bus.div_by_zero, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        check("midreset no done", ndone, 0);
        run_op("50/6", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0, LAT);

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op("-100/7", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, LAT);
        run_op("100/-7", 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, LAT);
        run_op("-128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, LAT);
        run_op("-5/0", 8'hFB, 8'd0, 8'hFF, 8'hFB, 1'b1, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
